divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 129 ++++++++++++
 tb/tb_divider.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Signed 32-bit restoring divider, one quotient bit per cycle.
// Truncates toward zero; remainder takes the dividend's sign (MIPS div).
module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividendo,
  input  logic [31:0] divisor,
  output logic [31:0] quociente,
  output logic [31:0] resto,
  output logic        calculando,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sdd_q, sdd_d;
  logic        sdv_q, sdv_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        dz_q, dz_d;

  logic [32:0] shf;
  logic [32:0] diff;
  logic [31:0] dd_mag;
  logic [31:0] dv_mag;

  // Operand magnitudes; 0x80000000 maps to itself, read as unsigned 2^31.
  always_comb begin
    dd_mag = dividendo[31] ? (32'd0 - dividendo) : dividendo;
    dv_mag = divisor[31] ? (32'd0 - divisor) : divisor;
    shf    = {r_q, q_q[31]};
    diff   = shf - {1'b0, dvs_q};
  end

  // Next-state and datapath: start always wins, then the FSM step.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    sdd_d   = sdd_q;
    sdv_d   = sdv_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    if (start) begin
      if (divisor == 32'd0) begin
        dz_d    = 1'b1;
        quo_d   = 32'd0;
        rem_d   = 32'd0;
        state_d = IDLE;
      end else begin
        q_d     = dd_mag;
        dvs_d   = dv_mag;
        sdd_d   = dividendo[31];
        sdv_d   = divisor[31];
        r_d     = 32'd0;
        cnt_d   = 6'd0;
        dz_d    = 1'b0;
        state_d = CALC;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        CALC: begin
          if (!diff[32]) begin
            r_d = diff[31:0];
            q_d = {q_q[30:0], 1'b1};
          end else begin
            r_d = shf[31:0];
            q_d = {q_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = FIX;
        end
        FIX: begin
          quo_d   = (sdd_q ^ sdv_q) ? (32'd0 - q_q) : q_q;
          rem_d   = sdd_q ? (32'd0 - r_q) : r_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= 32'd0;
      q_q     <= 32'd0;
      dvs_q   <= 32'd0;
      sdd_q   <= 1'b0;
      sdv_q   <= 1'b0;
      cnt_q   <= 6'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      sdd_q   <= sdd_d;
      sdv_q   <= sdv_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign quociente  = quo_q;
  assign resto      = rem_q;
  assign calculando = (state_q != IDLE);
  assign div_zero   = dz_q;

endmodule

// File: tb/tb_divider.sv
// Bench for divider: scoreboard of expected quotient/remainder,
// checked when calculando drops after each launched division.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividendo;
  logic [31:0] divisor;
  logic [31:0] quociente;
  logic [31:0] resto;
  logic        calculando;
  logic        div_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .quociente (quociente),
    .resto     (resto),
    .calculando(calculando),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    longint sa, sb_, lq, lr;
    if (b == 32'd0) begin
      e.q = 0; e.r = 0; e.dz = 1'b1;
    end else begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      lq  = sa / sb_;
      lr  = sa % sb_;
      e.q = lq[31:0]; e.r = lr[31:0]; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Launch a start pulse without expecting a result (aborted runs).
  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; dividendo = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_div(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] pq, pr;
    int          cyc;
    logic        held;
    exp_t        e;
    @(negedge clk);
    pq = quociente; pr = resto;
    start = 1'b1; dividendo = a; divisor = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    cyc = 0; held = 1'b1;
    while (calculando && cyc < 100) begin
      cyc++;
      if (quociente !== pq || resto !== pr) held = 1'b0;
      @(negedge clk);
    end
    e = sb.pop_front();
    if (b != 32'd0) begin
      chk({tag, ".busy"}, 32'(cyc), 32'd33);
      chk({tag, ".held"}, {31'd0, held}, 32'd1);
    end else begin
      chk({tag, ".busy"}, 32'(cyc), 32'd0);
    end
    chk({tag, ".quo"}, quociente, e.q);
    chk({tag, ".rem"}, resto, e.r);
    chk({tag, ".dz"}, {31'd0, div_zero}, {31'd0, e.dz});
  endtask

  initial begin
    logic [31:0] pq, pr, a, b;
    reset = 1'b1; start = 1'b0;
    dividendo = 0; divisor = 0;
    repeat (3) @(negedge clk);
    chk("rst.quo", quociente, 0);
    chk("rst.rem", resto, 0);
    chk("rst.busy", {31'd0, calculando}, 0);
    chk("rst.dz", {31'd0, div_zero}, 0);
    reset = 1'b0;

    run_div("p100_7", 32'd100, 32'd7);
    run_div("n100_7", -32'sd100, 32'd7);
    run_div("p100_n7", 32'd100, -32'sd7);
    run_div("n100_n7", -32'sd100, -32'sd7);
    chk("n100_n7.q14", quociente, 32'd14);

    // Divide by zero: flag and zeros on the very next cycle.
    run_div("dz", 32'h1234, 32'd0);
    @(negedge clk);
    chk("dz.idle", {31'd0, calculando}, 0);
    run_div("d9_3", 32'd9, 32'd3);

    run_div("minneg", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("minneg.q", quociente, 32'h8000_0000);
    run_div("m1_min", 32'hFFFF_FFFF, 32'h8000_0000);

    // Reset mid-division: outputs zero, no late update.
    run_div("pre_rst", 32'd77, 32'd5);
    pulse(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst.quo", quociente, 0);
    chk("mrst.rem", resto, 0);
    chk("mrst.busy", {31'd0, calculando}, 0);
    repeat (40) @(negedge clk);
    chk("mrst.late_q", quociente, 0);
    chk("mrst.late_r", resto, 0);

    // Restart mid-division: old result must never show up.
    run_div("pre_abt", 32'd23, 32'd4);
    pq = quociente; pr = resto;
    pulse(32'd100, 32'd7);
    repeat (18) @(negedge clk);
    chk("abt.held_q", quociente, pq);
    chk("abt.held_r", resto, pr);
    run_div("d50_5", 32'd50, 32'd5);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 3) ? $urandom_range(1, 300) : $urandom;
      if (i == 5) b = -b;
      run_div($sformatf("rnd%0d", i), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
